// File: rtl/rf_wb_scheduler_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
package rf_wb_scheduler_pkg;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned DATA_W = 32;

   localparam logic [REG_AW-1:0] REG_ZERO = '0;

   // One buffered MDU result: destination register and its data.
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] wd;
   } wb_entry_t;

   // Which source owns the RF write port in the current cycle.
   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_PIPE = 2'd1,
      GNT_FIFO = 2'd2
   } gnt_src_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous MDU result buffer: power-of-two depth, full/empty flags,
// no write-to-read bypass (a pushed entry is visible from the next cycle).
module rf_wb_fifo
   import rf_wb_scheduler_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic      clk,
   input  logic      rstn,
   input  logic      push,
   input  wb_entry_t push_data,
   input  logic      pop,
   output wb_entry_t head,
   output logic      full,
   output logic      empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   wb_entry_t       mem_q [DEPTH];
   wb_entry_t       mem_d [DEPTH];
   logic [AW:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]     rd_ptr_q, rd_ptr_d;
   logic            do_push;
   logic            do_pop;

   // Flags from the extra pointer wrap bit; head is the oldest entry.
   always_comb begin
      empty   = (wr_ptr_q == rd_ptr_q);
      full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      head    = mem_q[rd_ptr_q[AW-1:0]];
      do_push = push & ~full;
      do_pop  = pop & ~empty;
   end

   // Next storage and pointer values.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data;
         wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Storage and pointer registers; reset empties the buffer.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates between the in-order WB
// stage and buffered MDU results, tracks MDU destinations in a busy
// scoreboard, stalls ID on hazards against them and gates MDU issue.
module rf_wb_scheduler
   import rf_wb_scheduler_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned MAX_OUT    = 4,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   output logic              iss_ready,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_rd_we,
   output logic              id_stall,
   input  logic              pipe_we,
   input  logic [REG_AW-1:0] pipe_wa,
   input  logic [DATA_W-1:0] pipe_wd,
   output logic              wb_hold,
   input  logic              mdu_valid,
   input  logic [REG_AW-1:0] mdu_rd,
   input  logic [DATA_W-1:0] mdu_wd,
   output logic              mdu_ready,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_wa,
   output logic [DATA_W-1:0] rf_wd,
   output logic [2:0]        outstanding
);

   localparam int unsigned SW         = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);
   localparam logic [2:0]  MAX_OUT_C  = 3'(MAX_OUT);

   logic [31:0]   busy_q, busy_d;
   logic [2:0]    count_q, count_d;
   logic [SW-1:0] starve_q, starve_d;

   logic          iss_fire;
   logic          force_fifo;
   gnt_src_e      gnt;

   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   wb_entry_t     fifo_in;
   wb_entry_t     fifo_head;

   rf_wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (fifo_push),
      .push_data (fifo_in),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Issue gating, ID hazard detection and MDU accept, all on registered state.
   always_comb begin
      iss_ready   = (count_q < MAX_OUT_C) & ~busy_q[iss_rd];
      iss_fire    = iss_valid & iss_ready;
      id_stall    = busy_q[id_rs1] | busy_q[id_rs2] | (id_rd_we & busy_q[id_rd]);
      mdu_ready   = ~fifo_full;
      fifo_push   = mdu_valid & mdu_ready;
      fifo_in.rd  = mdu_rd;
      fifo_in.wd  = mdu_wd;
      outstanding = count_q;
   end

   // Write-port arbitration: WB wins unless the FIFO head has starved.
   always_comb begin
      gnt        = GNT_NONE;
      wb_hold    = 1'b0;
      rf_we      = 1'b0;
      rf_wa      = '0;
      rf_wd      = '0;
      force_fifo = ~fifo_empty & (starve_q == STARVE_C);
      if (force_fifo) begin
         gnt     = GNT_FIFO;
         wb_hold = pipe_we;
      end else if (pipe_we) begin
         gnt = GNT_PIPE;
      end else if (!fifo_empty) begin
         gnt = GNT_FIFO;
      end
      case (gnt)
         GNT_PIPE: begin
            rf_we = (pipe_wa != REG_ZERO);
            rf_wa = pipe_wa;
            rf_wd = pipe_wd;
         end
         GNT_FIFO: begin
            rf_we = (fifo_head.rd != REG_ZERO);
            rf_wa = fifo_head.rd;
            rf_wd = fifo_head.wd;
         end
         default: ;
      endcase
      fifo_pop = (gnt == GNT_FIFO);
   end

   // Scoreboard, outstanding counter and starvation counter updates.
   always_comb begin
      busy_d = busy_q;
      if (fifo_pop) begin
         busy_d[fifo_head.rd] = 1'b0;
      end
      // iss_ready guarantees the set bit differs from the retired one.
      if (iss_fire) begin
         busy_d[iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;

      count_d = count_q;
      case ({iss_fire, fifo_pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: ;
      endcase

      starve_d = starve_q;
      if (fifo_empty || fifo_pop) begin
         starve_d = '0;
      end else if (starve_q != STARVE_C) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // State registers; reset drops all busy bits and counts.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy_q   <= '0;
         count_q  <= '0;
         starve_q <= '0;
      end else begin
         busy_q   <= busy_d;
         count_q  <= count_d;
         starve_q <= starve_d;
      end
   end

   // WB must never target a register with an MDU result still pending.
   a_pipe_not_busy: assert property (@(posedge clk) disable iff (!rstn)
      !(pipe_we && busy_q[pipe_wa]));

   // An MDU result implies an op was issued and not yet retired.
   a_mdu_has_owner: assert property (@(posedge clk) disable iff (!rstn)
      !(mdu_valid && (count_q == 3'd0)));

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Scoreboard bench for rf_wb_scheduler: a queue-based reference model
// predicts per-cycle status outputs and the sequence of RF writes.
module tb_rf_wb_scheduler;
   import rf_wb_scheduler_pkg::*;

   localparam int FD = 2;
   localparam int MO = 4;
   localparam int SM = 3;

   logic        clk = 1'b0;
   logic        rstn;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        iss_ready;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_rd_we;
   logic        id_stall;
   logic        pipe_we;
   logic [4:0]  pipe_wa;
   logic [31:0] pipe_wd;
   logic        wb_hold;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_wd;
   logic        mdu_ready;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic [2:0]  outstanding;

   always #5 clk = ~clk;

   rf_wb_scheduler #(
      .FIFO_DEPTH (FD),
      .MAX_OUT    (MO),
      .STARVE_MAX (SM)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .iss_valid   (iss_valid),
      .iss_rd      (iss_rd),
      .iss_ready   (iss_ready),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rd       (id_rd),
      .id_rd_we    (id_rd_we),
      .id_stall    (id_stall),
      .pipe_we     (pipe_we),
      .pipe_wa     (pipe_wa),
      .pipe_wd     (pipe_wd),
      .wb_hold     (wb_hold),
      .mdu_valid   (mdu_valid),
      .mdu_rd      (mdu_rd),
      .mdu_wd      (mdu_wd),
      .mdu_ready   (mdu_ready),
      .rf_we       (rf_we),
      .rf_wa       (rf_wa),
      .rf_wd       (rf_wd),
      .outstanding (outstanding)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   wb_entry_t  sb_q[$];     // expected RF writes, in order
   wb_entry_t  fifo_m[$];   // results accepted but not yet written
   logic [4:0] pend[$];     // destinations issued and not yet written
   logic [4:0] mdu_q[$];    // ops issued whose result the MDU still owes
   int         cnt;
   int         starve;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic bit is_busy(logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      foreach (pend[i]) if (pend[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   task automatic idle();
      iss_valid = 0; iss_rd = 0;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd_we = 0;
      pipe_we = 0; pipe_wa = 0; pipe_wd = 0;
      mdu_valid = 0; mdu_rd = 0; mdu_wd = 0;
   endtask

   task automatic present_mdu(input logic [31:0] wd);
      mdu_valid = 1'b1;
      mdu_rd    = mdu_q[0];
      mdu_wd    = wd;
   endtask

   // One clock cycle: predict, check at negedge, advance past posedge.
   task automatic tick();
      bit        e_iss_ready, e_stall, e_mdu_ready, e_hold;
      bit        frc, gnt_f, gnt_p, fire, acc;
      int        sz;
      wb_entry_t ent;
      sz          = fifo_m.size();
      e_iss_ready = (cnt < MO) && !is_busy(iss_rd);
      e_stall     = is_busy(id_rs1) || is_busy(id_rs2) || (id_rd_we && is_busy(id_rd));
      e_mdu_ready = (sz < FD);
      frc         = (sz > 0) && (starve == SM);
      gnt_f       = (sz > 0) && (frc || !pipe_we);
      gnt_p       = pipe_we && !frc;
      e_hold      = frc && pipe_we;
      fire        = iss_valid && e_iss_ready;
      acc         = mdu_valid && e_mdu_ready;
      if (gnt_f) begin
         ent = fifo_m.pop_front();
         if (ent.rd != 5'd0) sb_q.push_back(ent);
         for (int i = 0; i < pend.size(); i++) begin
            if (pend[i] == ent.rd) begin
               pend.delete(i);
               break;
            end
         end
         cnt--;
      end else if (gnt_p && pipe_wa != 5'd0) begin
         ent.rd = pipe_wa;
         ent.wd = pipe_wd;
         sb_q.push_back(ent);
      end
      if (sz == 0 || gnt_f) starve = 0;
      else if (starve < SM) starve++;
      if (fire) begin
         pend.push_back(iss_rd);
         cnt++;
      end
      if (acc) begin
         ent.rd = mdu_rd;
         ent.wd = mdu_wd;
         fifo_m.push_back(ent);
         void'(mdu_q.pop_front());
      end
      @(negedge clk);
      chk("iss_ready", {31'd0, iss_ready}, {31'd0, e_iss_ready});
      chk("id_stall", {31'd0, id_stall}, {31'd0, e_stall});
      chk("mdu_ready", {31'd0, mdu_ready}, {31'd0, e_mdu_ready});
      chk("wb_hold", {31'd0, wb_hold}, {31'd0, e_hold});
      chk("outstanding_before_edge", {29'd0, outstanding}, 32'(sz + pend.size() - pend.size()) * 0 + 32'(cnt + (gnt_f ? 1 : 0) - (fire ? 1 : 0)));
      @(posedge clk);
      #1;
      if (acc) mdu_valid = 1'b0;
   endtask

   // RF write monitor: every DUT write must match the next predicted write.
   always @(negedge clk) begin
      wb_entry_t e;
      if (rstn === 1'b1 && rf_we === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rf_write: got wa=%0d wd=%0h expected no write (t=%0t)", rf_wa, rf_wd, $time);
         end else begin
            e = sb_q.pop_front();
            chk("rf_wa", {27'd0, rf_wa}, {27'd0, e.rd});
            chk("rf_wd", rf_wd, e.wd);
         end
      end
   end

   task automatic do_reset();
      idle();
      rstn = 1'b0;
      #1;
      chk("rst_iss_ready", {31'd0, iss_ready}, 32'd1);
      chk("rst_id_stall", {31'd0, id_stall}, 32'd0);
      chk("rst_wb_hold", {31'd0, wb_hold}, 32'd0);
      chk("rst_mdu_ready", {31'd0, mdu_ready}, 32'd1);
      chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
      chk("rst_outstanding", {29'd0, outstanding}, 32'd0);
      chk("rst_pending_writes", 32'(sb_q.size()), 32'd0);
      sb_q.delete(); fifo_m.delete(); pend.delete(); mdu_q.delete();
      cnt = 0; starve = 0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic random_cycles(input int n);
      logic [4:0] wa;
      for (int k = 0; k < n; k++) begin
         iss_valid = ($urandom_range(0, 2) == 0);
         iss_rd    = 5'($urandom_range(0, 15));
         id_rs1    = 5'($urandom_range(0, 15));
         id_rs2    = 5'($urandom_range(0, 15));
         id_rd     = 5'($urandom_range(0, 15));
         id_rd_we  = 1'($urandom_range(0, 1));
         pipe_we   = 1'($urandom_range(0, 1));
         do wa = 5'($urandom_range(0, 31)); while (is_busy(wa));
         pipe_wa   = wa;
         pipe_wd   = $urandom;
         if (!mdu_valid && mdu_q.size() > 0 && $urandom_range(0, 2) == 0)
            present_mdu($urandom);
         tick();
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      iss_valid = 0; pipe_we = 0; id_rd_we = 0;
      while ((cnt != 0 || mdu_q.size() != 0) && guard < 60) begin
         if (!mdu_valid && mdu_q.size() > 0) present_mdu($urandom);
         tick();
         guard++;
      end
      chk("drain_outstanding", 32'(cnt), 32'd0);
      tick();
   endtask

   // Track MDU ops owed to the bench as they are issued.
   always @(negedge clk) begin
      if (rstn === 1'b1 && iss_valid === 1'b1 && iss_ready === 1'b1)
         mdu_q.push_back(iss_rd);
   end

   initial begin
      idle();
      cnt = 0; starve = 0;
      rstn = 1'b0;
      #1;
      @(posedge clk);
      #1;
      do_reset();

      // RAW stall on x5, released after the MDU result is written
      iss_valid = 1; iss_rd = 5; id_rs1 = 5;
      tick();
      iss_valid = 0;
      tick();
      present_mdu(32'h0000_1234);
      tick();
      tick();
      tick();
      id_rs1 = 0;

      // Starvation: x7 result waits behind continuous WB writes
      iss_valid = 1; iss_rd = 7;
      tick();
      iss_valid = 0;
      present_mdu(32'h0000_7777);
      pipe_we = 1; pipe_wa = 10; pipe_wd = 32'hABCD_0010;
      repeat (7) tick();
      pipe_we = 0;
      tick();

      // Backpressure: MAX_OUT reached, FIFO fills under WB pressure
      for (int r = 1; r <= 4; r++) begin
         iss_valid = 1; iss_rd = 5'(r);
         tick();
      end
      iss_rd = 6;
      tick();
      iss_valid = 0;
      pipe_we = 1; pipe_wa = 20; pipe_wd = 32'h5555_0020;
      for (int k = 0; k < 14; k++) begin
         if (!mdu_valid && mdu_q.size() > 0) present_mdu($urandom);
         tick();
      end
      pipe_we = 0;
      drain();

      // x0 destination: counted, never busy, never written
      iss_valid = 1; iss_rd = 0; id_rs1 = 0;
      tick();
      iss_valid = 0;
      tick();
      present_mdu(32'hDEAD_0000);
      tick();
      tick();
      tick();

      // WAW: re-issue of x9 blocked until its pending result is written
      iss_valid = 1; iss_rd = 9;
      tick();
      id_rd = 9; id_rd_we = 1;
      tick();
      tick();
      present_mdu(32'h0000_0909);
      tick();
      tick();
      tick();
      iss_valid = 0; id_rd_we = 0;
      drain();

      random_cycles(300);
      do_reset();
      random_cycles(300);
      drain();

      chk("final_pending_writes", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
